// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame width, majority vote.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int UART_DATA_BITS = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous serial line; resets to the idle (high) level.
// Latency SYNC_STAGES cycles, no backpressure.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_din,
  output logic o_rx
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
    end
  end

  assign o_rx = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_framer.sv
// 8N1 UART receiver with 3-sample majority filter; byte valid 1 cycle after the stop-bit decision.
// Holds one byte until ready; a byte completing while one is still held is dropped with an overrun pulse.
module uart_rx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW  = $clog2(CLKS_PER_BIT);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] MID_LO    = TW'(MID - 1);
  localparam logic [TW-1:0] MID_C     = TW'(MID);
  localparam logic [TW-1:0] MID_HI    = TW'(MID + 1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  logic        w_rx;
  logic        w_maj;
  logic        w_mid_hi;
  logic        w_accept;

  uart_state_e r_state;
  logic        r_rx_prev;
  logic [TW-1:0] r_tick;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_samp;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_fe;
  logic        r_ov;
  logic        r_busy;

  uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_din (din),
    .o_rx  (w_rx)
  );

  // Third vote is the live sample, so the decision lands exactly on MID+1.
  assign w_maj    = maj3(r_samp[0], r_samp[1], w_rx);
  assign w_mid_hi = (r_tick == MID_HI);
  assign w_accept = r_valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_rx_prev <= 1'b1;
      r_tick    <= '0;
      r_bit_cnt <= '0;
      r_samp    <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_fe      <= 1'b0;
      r_ov      <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_rx_prev <= w_rx;
      r_fe      <= 1'b0;
      r_ov      <= 1'b0;
      r_tick    <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
      if (r_tick == MID_LO) r_samp[0] <= w_rx;
      if (r_tick == MID_C)  r_samp[1] <= w_rx;
      if (w_accept) r_valid <= 1'b0;

      case (r_state)
        IDLE: begin
          // Edge-triggered arming: a line held low after a bad stop bit never restarts a frame.
          if (r_rx_prev && !w_rx) begin
            r_tick  <= '0;
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          if (w_mid_hi) begin
            if (!w_maj) begin
              r_tick    <= '0;
              r_bit_cnt <= '0;
              r_state   <= DATA;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        DATA: begin
          if (w_mid_hi) r_shift <= {w_maj, r_shift[7:1]};
          if (r_tick == TICK_LAST) begin
            if (r_bit_cnt == LAST_BIT) r_state <= STOP;
            else                       r_bit_cnt <= r_bit_cnt + 3'd1;
          end
        end
        STOP: begin
          if (w_mid_hi) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (w_maj) begin
              if (!r_valid || ready) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_ov <= 1'b1;
              end
            end else begin
              r_fe <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_fe;
  assign overrun   = r_ov;
  assign busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Randomised 8N1 stimulus against a frame-level model: expected byte queue plus error counters.
module tb_uart_rx_framer;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun, busy;

  uart_rx_framer #(.CLKS_PER_BIT(C), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .data_out  (data_out),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  logic [7:0] exp_q[$];
  int exp_fe = 0;
  int exp_ov = 0;
  int model_held = 0;
  bit model_hold_mode = 1'b0;

  // Observed state
  int n_fe = 0, n_ov = 0, n_hs = 0, n_vcyc = 0;
  logic [7:0] last_got = 8'h00;
  logic prev_valid = 1'b0, prev_hs = 1'b0, prev_fe = 1'b0, prev_ov = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int ready_mode = 0;  // 0 low, 1 high, 2 random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit stop_ok);
    if (!stop_ok) exp_fe++;
    else if (model_hold_mode && model_held > 0) exp_ov++;
    else begin
      exp_q.push_back(b);
      if (model_hold_mode) model_held++;
    end
  endtask

  // spike_bit: data bit index (0..7) that gets a one-cycle inversion at spike_off, or -1 for none.
  // The line is left at the stop-bit level on return.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int spike_bit, input int spike_off);
    logic [9:0] bits;
    model_frame(b, stop_ok);
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      din = bits[i];
      if (i >= 1 && i <= 8 && spike_bit == i - 1) begin
        tick(spike_off);
        din = ~bits[i];
        tick(1);
        din = bits[i];
        tick(C - spike_off - 1);
      end else begin
        tick(C);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        default: ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_hs    = 1'b0;
        prev_fe    = 1'b0;
        prev_ov    = 1'b0;
      end else begin
        if (valid) n_vcyc++;
        if (valid && prev_valid && !prev_hs) check("data_stable", data_out, prev_data);
        if (valid && ready) begin
          n_hs++;
          last_got = data_out;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_byte: got 0x%0h, expected none", data_out);
          end else begin
            check("rx_byte", data_out, exp_q.pop_front());
          end
        end
        if (prev_fe) check("frame_err_width", frame_err, 1'b0);
        if (prev_ov) check("overrun_width", overrun, 1'b0);
        if (frame_err) n_fe++;
        if (overrun) n_ov++;
        prev_hs    = valid && ready;
        prev_valid = valid;
        prev_data  = data_out;
        prev_fe    = frame_err;
        prev_ov    = overrun;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, fe0, ov0, h0;
    bit saw, got;
    logic [7:0] b;
    logic [7:0] p99;
    bit ok;
    int sp, off;

    tick(3);
    check("rst_data", data_out, 8'h00);
    check("rst_valid", valid, 1'b0);
    check("rst_fe", frame_err, 1'b0);
    check("rst_ov", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    ready_mode = 1;
    tick(2 * C);

    // Single byte, always-ready consumer
    v0 = n_vcyc; fe0 = n_fe; ov0 = n_ov;
    send_frame(8'hA5, 1'b1, -1, 0);
    tick(C);
    check("a5_valid_cycles", n_vcyc - v0, 1);
    check("a5_data", last_got, 8'hA5);
    check("a5_no_fe", n_fe - fe0, 0);
    check("a5_no_ov", n_ov - ov0, 0);

    // Back-to-back frames, no idle gap
    h0 = n_hs;
    send_frame(8'h3C, 1'b1, -1, 0);
    send_frame(8'hC3, 1'b1, -1, 0);
    tick(C);
    check("b2b_count", n_hs - h0, 2);
    check("b2b_last", last_got, 8'hC3);

    // Bad stop bit followed by a long break
    v0 = n_vcyc; fe0 = n_fe;
    send_frame(8'h55, 1'b0, -1, 0);
    tick(40 * C);
    check("break_fe_once", n_fe - fe0, 1);
    check("break_no_valid", n_vcyc - v0, 0);
    din = 1'b1;
    tick(2 * C);
    send_frame(8'h01, 1'b1, -1, 0);
    tick(C);
    check("after_break_data", last_got, 8'h01);

    // Stalled consumer: oldest byte kept, second dropped
    ready_mode = 0;
    tick(2);
    model_hold_mode = 1'b1;
    model_held = 0;
    ov0 = n_ov;
    send_frame(8'h11, 1'b1, -1, 0);
    send_frame(8'h22, 1'b1, -1, 0);
    tick(C);
    check("ovr_valid", valid, 1'b1);
    check("ovr_data", data_out, 8'h11);
    check("ovr_once", n_ov - ov0, 1);
    model_hold_mode = 1'b0;
    model_held = 0;
    ready_mode = 1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (valid && ready) begin
        got = 1'b1;
        break;
      end
    end
    check("ovr_handshake_seen", got, 1'b1);
    @(negedge clk);
    check("valid_drop", valid, 1'b0);
    tick(C);

    // Short low glitch on an idle line
    v0 = n_vcyc; fe0 = n_fe;
    din = 1'b0;
    tick(3);
    din = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (busy) saw = 1'b1;
    end
    check("glitch_busy_rose", saw, 1'b1);
    check("glitch_idle", busy, 1'b0);
    check("glitch_no_valid", n_vcyc - v0, 0);
    check("glitch_no_fe", n_fe - fe0, 0);

    // Single-cycle spikes landing on the middle vote sample
    send_frame(8'hF0, 1'b1, 2, 3);
    tick(C);
    check("spike_data_lo", last_got, 8'hF0);
    send_frame(8'hF0, 1'b1, 6, 3);
    tick(C);
    check("spike_data_hi", last_got, 8'hF0);

    // Reset during bit 4 of 0x99
    p99 = 8'h99;
    din = 1'b0;
    tick(C);
    for (int i = 0; i < 4; i++) begin
      din = p99[i];
      tick(C);
    end
    din = p99[4];
    tick(C / 2);
    rst_n = 1'b0;
    #1;
    check("midrst_data", data_out, 8'h00);
    check("midrst_valid", valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_fe", frame_err, 1'b0);
    check("midrst_ov", overrun, 1'b0);
    din = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check("postrst_busy", busy, 1'b0);
    check("postrst_valid", valid, 1'b0);
    tick(2 * C);
    send_frame(8'h99, 1'b1, -1, 0);
    tick(C);
    check("postrst_data", last_got, 8'h99);

    // Randomised traffic with a jittery consumer
    ready_mode = 2;
    for (int n = 0; n < 30; n++) begin
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 5) != 0);
      sp  = int'($urandom_range(0, 8)) - 1;
      off = int'($urandom_range(0, C - 1));
      send_frame(b, ok, sp, off);
      if (!ok) begin
        din = 1'b1;
        tick(2 + int'($urandom_range(0, 10)));
      end else begin
        tick(int'($urandom_range(0, 20)));
      end
    end

    ready_mode = 1;
    din = 1'b1;
    tick(3 * C);
    check("queue_drained", exp_q.size(), 0);
    check("fe_total", n_fe, exp_fe);
    check("ov_total", n_ov, exp_ov);
    check("final_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
